// File: rtl/div_n.sv
// div_n: programmable clock divider, ratio N and high-count H per period; optional duty input under `DIV_DUTY_EN.
// Latency: outputs registered, 1 pre_div edge after the enabled edge; new ratio takes effect only at a period wrap.
// Backpressure: none; en=0 freezes the phase and a load still lands in the pending register.
module div_n #(
  parameter int WIDTH         = 8,
  parameter int DEFAULT_RATIO = 2
) (
  input  logic             pre_div,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div_ratio,
`ifdef DIV_DUTY_EN
  input  logic [WIDTH-1:0] duty_hi,
`endif
  output logic             div_out,
  output logic             tick,
  output logic             upd_ack,
  output logic [WIDTH-1:0] cur_ratio
);

  localparam logic [WIDTH-1:0] RST_RATIO = WIDTH'(DEFAULT_RATIO);
  localparam logic [WIDTH-1:0] RST_DUTY  = WIDTH'(DEFAULT_RATIO / 2);
  localparam logic [WIDTH-1:0] MIN_RATIO = WIDTH'(2);

  logic [WIDTH-1:0] ph;
  logic [WIDTH-1:0] ratio;
  logic [WIDTH-1:0] duty;
  logic [WIDTH-1:0] pend_ratio;
  logic [WIDTH-1:0] pend_duty;
  logic             pend_valid;

  logic             ph_last;
  logic [WIDTH-1:0] ph_next;
  logic [WIDTH-1:0] low_cnt;
  logic             apply;
  logic [WIDTH-1:0] ld_ratio;
  logic [WIDTH-1:0] ld_duty;

  always_comb begin
    ph_last  = (ph == ratio - WIDTH'(1));
    ph_next  = ph_last ? '0 : ph + WIDTH'(1);
    low_cnt  = ratio - duty;
    // pend_valid is the pre-edge value, so a load on the wrap edge waits a period
    apply    = en && ph_last && pend_valid;
    ld_ratio = (div_ratio < MIN_RATIO) ? MIN_RATIO : div_ratio;
`ifdef DIV_DUTY_EN
    if (duty_hi == '0)
      ld_duty = WIDTH'(1);
    else if (duty_hi >= ld_ratio)
      ld_duty = ld_ratio - WIDTH'(1);
    else
      ld_duty = duty_hi;
`else
    ld_duty  = ld_ratio >> 1;
`endif
  end

  always_ff @(posedge pre_div) begin
    if (rst) begin
      ph         <= '0;
      div_out    <= 1'b0;
      tick       <= 1'b0;
      upd_ack    <= 1'b0;
      ratio      <= RST_RATIO;
      duty       <= RST_DUTY;
      pend_ratio <= RST_RATIO;
      pend_duty  <= RST_DUTY;
      pend_valid <= 1'b0;
    end else begin
      upd_ack <= apply;
      tick    <= en && ph_last;
      if (en) begin
        ph      <= ph_next;
        div_out <= (ph_next >= low_cnt);
      end
      if (apply) begin
        ratio <= pend_ratio;
        duty  <= pend_duty;
      end
      if (load) begin
        pend_ratio <= ld_ratio;
        pend_duty  <= ld_duty;
        pend_valid <= 1'b1;
      end else if (apply) begin
        pend_valid <= 1'b0;
      end
    end
  end

  assign cur_ratio = ratio;

endmodule

// File: tb/tb_div_n.sv
// Bench for div_n: directed vector table, hand corner sequences, then random traffic against a period-level model.
module tb_div_n;

  localparam int W = 8;

  logic         pre_div = 1'b0;
  logic         rst = 1'b0, en = 1'b0, load = 1'b0;
  logic [W-1:0] div_ratio = '0;
  logic [W-1:0] duty_in = '0;
  logic         div_out, tick, upd_ack;
  logic [W-1:0] cur_ratio;

  int total = 0;
  int bad   = 0;

  div_n #(.WIDTH(W), .DEFAULT_RATIO(2)) dut (
    .pre_div  (pre_div),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .div_ratio(div_ratio),
`ifdef DIV_DUTY_EN
    .duty_hi  (duty_in),
`endif
    .div_out  (div_out),
    .tick     (tick),
    .upd_ack  (upd_ack),
    .cur_ratio(cur_ratio)
  );

  always #5 pre_div = ~pre_div;

  // Model: position within the current period, period length, high count, pending request.
  int m_pos, m_n, m_h, m_pn, m_pd, m_pv;
  bit m_out, m_tick, m_ack;

  function automatic int clamp_ratio(input int r);
    return (r < 2) ? 2 : r;
  endfunction

  function automatic int clamp_duty(input int n, input int d);
`ifdef DIV_DUTY_EN
    if (d < 1) return 1;
    if (d > n - 1) return n - 1;
    return d;
`else
    return n / 2;
`endif
  endfunction

  task automatic model_step(input bit r, input bit e, input bit l, input int dr, input int dd);
    if (r) begin
      m_pos = 0; m_n = 2; m_h = 1; m_pv = 0;
      m_out = 0; m_tick = 0; m_ack = 0;
      return;
    end
    m_tick = 0;
    m_ack  = 0;
    if (e) begin
      m_pos  = (m_pos + 1) % m_n;
      m_out  = (m_pos >= m_n - m_h);
      m_tick = (m_pos == 0);
      if (m_pos == 0 && m_pv != 0) begin
        m_n = m_pn; m_h = m_pd; m_pv = 0; m_ack = 1;
      end
    end
    if (l) begin
      m_pn = clamp_ratio(dr);
      m_pd = clamp_duty(m_pn, dd);
      m_pv = 1;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit l, input int dr, input int dd);
    rst = r; en = e; load = l; div_ratio = W'(dr); duty_in = W'(dd);
    @(posedge pre_div);
    #1;
    model_step(r, e, l, dr, dd);
    rst = 1'b0; en = 1'b0; load = 1'b0;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".div_out"}, int'(div_out), int'(m_out));
    chk({tag, ".tick"}, int'(tick), int'(m_tick));
    chk({tag, ".upd_ack"}, int'(upd_ack), int'(m_ack));
    chk({tag, ".cur_ratio"}, int'(cur_ratio), m_n);
  endtask

  typedef struct {
    bit r, e, l;
    int dr;
    bit x_out, x_tick, x_ack;
    int x_ratio;
  } vec_t;

  vec_t vt[$];

  initial begin
    int cnt, hi;

    // reset, N=2 toggling, load 5 mid-period, 3 low / 2 high, load 0 clamps to 2, en=0 hold
    vt.push_back('{1,0,0,0, 0,0,0,2});
    vt.push_back('{0,1,0,0, 1,0,0,2});
    vt.push_back('{0,1,0,0, 0,1,0,2});
    vt.push_back('{0,1,1,5, 1,0,0,2});
    vt.push_back('{0,1,0,0, 0,1,1,5});
    vt.push_back('{0,1,0,0, 0,0,0,5});
    vt.push_back('{0,1,0,0, 0,0,0,5});
    vt.push_back('{0,1,0,0, 1,0,0,5});
    vt.push_back('{0,1,0,0, 1,0,0,5});
    vt.push_back('{0,1,0,0, 0,1,0,5});
    vt.push_back('{0,1,1,0, 0,0,0,5});
    vt.push_back('{0,1,0,0, 0,0,0,5});
    vt.push_back('{0,1,0,0, 1,0,0,5});
    vt.push_back('{0,1,0,0, 1,0,0,5});
    vt.push_back('{0,1,0,0, 0,1,1,2});
    vt.push_back('{0,1,0,0, 1,0,0,2});
    vt.push_back('{0,0,0,0, 1,0,0,2});
    vt.push_back('{0,1,0,0, 0,1,0,2});

    foreach (vt[i]) begin
      step(vt[i].r, vt[i].e, vt[i].l, vt[i].dr, 0);
      chk($sformatf("vec%0d.div_out", i), int'(div_out), int'(vt[i].x_out));
      chk($sformatf("vec%0d.tick", i), int'(tick), int'(vt[i].x_tick));
      chk($sformatf("vec%0d.upd_ack", i), int'(upd_ack), int'(vt[i].x_ack));
      chk($sformatf("vec%0d.cur_ratio", i), int'(cur_ratio), vt[i].x_ratio);
    end

    // N=4, en low for 3 cycles at ph=2: hold, then exactly 4 enabled cycles per period
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 4, 2);
    step(0, 1, 0, 0, 0);
    chk_model("n4_apply");
    chk("n4_ratio", int'(cur_ratio), 4);
    cnt = 0;
    step(0, 1, 0, 0, 0); cnt++;
    step(0, 1, 0, 0, 0); cnt++;
    chk("n4_ph2_out", int'(div_out), 1);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 0);
      chk("hold_out", int'(div_out), 1);
      chk("hold_tick", int'(tick), 0);
    end
    for (int k = 0; k < 8 && tick !== 1'b1; k++) begin
      step(0, 1, 0, 0, 0);
      cnt++;
    end
    chk("n4_wrap_seen", int'(tick), 1);
    chk("n4_period_len", cnt, 4);

    // load on the wrap edge lands at the following wrap
    for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 6, 3);
    chk("wrapload_tick", int'(tick), 1);
    chk("wrapload_no_ack", int'(upd_ack), 0);
    chk("wrapload_ratio_old", int'(cur_ratio), 4);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("wrapload_ack", int'(upd_ack), 1);
    chk("wrapload_ratio_new", int'(cur_ratio), 6);

    // reset with a pending update (and a coincident load) discards it
    step(0, 1, 1, 3, 1);
    step(1, 1, 1, 7, 3);
    chk_model("rst_pend");
    chk("rst_ratio", int'(cur_ratio), 2);
    step(0, 1, 0, 0, 0);
    chk("rst_first_out", int'(div_out), 1);
    for (int k = 0; k < 10; k++) begin
      step(0, 1, 0, 0, 0);
      chk("rst_no_ack", int'(upd_ack), 0);
      chk("rst_ratio_keep", int'(cur_ratio), 2);
    end

`ifdef DIV_DUTY_EN
    // ratio 8 with duty 9 -> H=7: one low, seven high
    step(0, 1, 1, 8, 9);
    for (int k = 0; k < 4 && upd_ack !== 1'b1; k++) step(0, 1, 0, 0, 0);
    chk("duty_applied", int'(cur_ratio), 8);
    hi = 0;
    for (int k = 0; k < 8; k++) begin
      step(0, 1, 0, 0, 0);
      chk_model("duty");
      hi += int'(div_out);
    end
    chk("duty_high_cnt", hi, 7);
`else
    hi = 0;
`endif

    // random traffic against the model
    for (int k = 0; k < 600; k++) begin
      bit r, e, l;
      r = ($urandom_range(0, 99) < 1);
      e = ($urandom_range(0, 99) < 80);
      l = ($urandom_range(0, 99) < 6);
      step(r, e, l, int'($urandom_range(0, 12)), int'($urandom_range(0, 14)));
      chk_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
